sound_frame_sequencer: RTL and testbench
========================================

Name: sound_frame_sequencer

Overview:
- Shared timebase/scheduler for all four GBC sound channels.
- Divides the 33 MHz sound clock into the 512 Hz frame sequencer and steps an 8-step schedule.
- Emits single-cycle length (256 Hz), sweep (128 Hz) and envelope (64 Hz) ticks that channel blocks consume instead of keeping private 32-bit timers.
- Gated by the NR52 master sound enable. Sits between the NR52 register decode and the sound_channel1..4 instances.

Parameters:
CLKS_PER_STEP, 64453, I_CLK cycles per frame-sequencer step (33 MHz / 512); must be >= 2
DIV_WIDTH, 17, width of divider counter; must satisfy 2^DIV_WIDTH > CLKS_PER_STEP

Ports:
I_CLK  input  1  33 MHz sound clock; all logic on rising edge
I_RESET  input  1  synchronous reset, active-high
I_SOUND_ON  input  1  NR52 bit 7 master sound enable, level
O_LENGTH_TICK  output  1  one-cycle pulse, length counters decrement
O_SWEEP_TICK  output  1  one-cycle pulse, channel 1 frequency sweep update
O_ENVELOPE_TICK  output  1  one-cycle pulse, volume envelope step
O_FRAME_WRAP  output  1  one-cycle pulse when step wraps 7->0
O_STEP  output  3  current step index, registered

Behaviour:
- One clock; reset is synchronous and active-high. I_CLK and I_RESET as named above.
- Reset values:
  - divider = 0, step = 7.
  - All tick outputs = 0; O_STEP = 7.
  - I_RESET dominates every other input in the same cycle.
- States: OFF (I_SOUND_ON=0) and RUN (I_SOUND_ON=1). The state is registered as the sampled I_SOUND_ON.
- OFF behaviour:
  - Divider forced to 0, step forced to 7, all ticks 0.
  - Re-entering RUN always starts a full period from step 7. The first emitted step is 0, exactly CLKS_PER_STEP cycles after the first RUN cycle.
- RUN behaviour:
  - Divider increments by 1 each cycle.
  - On the edge where divider == CLKS_PER_STEP-1: divider <= 0 and step <= step+1 mod 8 (3-bit wrap, 7->0).
  - Tick registers load from the new step value on that same edge. Ticks are therefore high during the single cycle after rollover, coincident with the new O_STEP value.
- Tick decode on the new step:
  - Length: steps 0, 2, 4, 6.
  - Sweep: steps 2, 6.
  - Envelope: step 7.
  - O_FRAME_WRAP: step 0.
  - All other cycles: ticks 0. Ticks are never high for more than one consecutive cycle.
- Rates: length = 4 pulses, sweep = 2, envelope = 1, frame wrap = 1 per 8*CLKS_PER_STEP cycles.
- Simultaneous events:
  - I_SOUND_ON falling in the rollover cycle: OFF wins. No tick, divider 0, step 7.
  - I_SOUND_ON rising: that cycle counts as divider 0 (divider held at 0 entering RUN).
- Reset mid-period: the partial period is discarded. The next tick is a length tick at step 0, CLKS_PER_STEP cycles after reset deasserts (given I_SOUND_ON=1).
- No combinational path from inputs to outputs; all outputs are registered.

Test Plan:
- CLKS_PER_STEP=4, I_RESET 1 cycle then I_SOUND_ON=1 held -> first O_LENGTH_TICK and O_FRAME_WRAP on cycle 4 after reset release with O_STEP=0; O_STEP sequence 0..7 every 4 cycles.
- CLKS_PER_STEP=4, run 64 cycles -> exactly 8 length, 4 sweep, 2 envelope, 2 frame-wrap pulses; sweep only with O_STEP 2/6, envelope only with O_STEP 7.
- CLKS_PER_STEP=4, drop I_SOUND_ON at step 3 mid-period, restore after 10 cycles -> no ticks while off, O_STEP=7; next length tick 4 cycles after restore with O_STEP=0.
- CLKS_PER_STEP=4, drop I_SOUND_ON exactly on rollover cycle into step 6 -> no length/sweep pulse, O_STEP=7 next cycle.
- CLKS_PER_STEP=4, assert I_RESET at step 5 with I_SOUND_ON=1 -> outputs 0, O_STEP=7 next cycle; sequence restarts at step 0 after 4 cycles.
- Default parameters, run 8*64453 cycles -> exactly one envelope tick and four length ticks; period between envelope ticks = 515624 cycles.

Source files
------------

// File: rtl/sound_frame_sequencer.sv
// Frame sequencer shared by the four sound channels: divides the sound clock into 512 Hz steps
// and emits single-cycle length, sweep and envelope ticks on an 8-step schedule.
module sound_frame_sequencer #(
    parameter int unsigned CLKS_PER_STEP = 64453,
    parameter int unsigned DIV_WIDTH     = 17
) (
    input  logic       I_CLK,
    input  logic       I_RESET,
    input  logic       I_SOUND_ON,
    output logic       O_LENGTH_TICK,
    output logic       O_SWEEP_TICK,
    output logic       O_ENVELOPE_TICK,
    output logic       O_FRAME_WRAP,
    output logic [2:0] O_STEP
);

    localparam logic [DIV_WIDTH-1:0] DivLast = DIV_WIDTH'(CLKS_PER_STEP - 1);

    logic [DIV_WIDTH-1:0] div_q, div_d;
    logic [2:0]           step_q, step_d;
    logic                 len_q, len_d;
    logic                 swp_q, swp_d;
    logic                 env_q, env_d;
    logic                 wrap_q, wrap_d;

    always_comb begin
        div_d  = div_q + 1'b1;
        step_d = step_q;
        len_d  = 1'b0;
        swp_d  = 1'b0;
        env_d  = 1'b0;
        wrap_d = 1'b0;
        if (div_q == DivLast) begin
            div_d  = '0;
            step_d = step_q + 3'd1;
            // Ticks decode the step being entered so they line up with the new O_STEP.
            len_d  = ~step_d[0];
            swp_d  = (step_d[1:0] == 2'b10);
            env_d  = (step_d == 3'd7);
            wrap_d = (step_d == 3'd0);
        end
        // Sound off parks the sequencer so the next enable starts a full period at step 7.
        if (!I_SOUND_ON) begin
            div_d  = '0;
            step_d = 3'd7;
            len_d  = 1'b0;
            swp_d  = 1'b0;
            env_d  = 1'b0;
            wrap_d = 1'b0;
        end
    end

    always_ff @(posedge I_CLK) begin
        if (I_RESET) begin
            div_q  <= '0;
            step_q <= 3'd7;
            len_q  <= 1'b0;
            swp_q  <= 1'b0;
            env_q  <= 1'b0;
            wrap_q <= 1'b0;
        end else begin
            div_q  <= div_d;
            step_q <= step_d;
            len_q  <= len_d;
            swp_q  <= swp_d;
            env_q  <= env_d;
            wrap_q <= wrap_d;
        end
    end

    assign O_LENGTH_TICK   = len_q;
    assign O_SWEEP_TICK    = swp_q;
    assign O_ENVELOPE_TICK = env_q;
    assign O_FRAME_WRAP    = wrap_q;
    assign O_STEP          = step_q;

endmodule

// File: tb/tb_sound_frame_sequencer.sv
// Directed bench for sound_frame_sequencer: table-driven schedule check plus hand-written
// sequences for sound-off, rollover-collision and mid-period reset cases.
module tb_sound_frame_sequencer;

    logic       clk = 1'b0;
    logic       rst, son;
    logic       len, swp, env, wrap;
    logic [2:0] step;
    logic       rst2;
    logic       len2, swp2, env2, wrap2;
    logic [2:0] step2;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    sound_frame_sequencer #(.CLKS_PER_STEP(4), .DIV_WIDTH(3)) u_dut (
        .I_CLK(clk), .I_RESET(rst), .I_SOUND_ON(son),
        .O_LENGTH_TICK(len), .O_SWEEP_TICK(swp), .O_ENVELOPE_TICK(env),
        .O_FRAME_WRAP(wrap), .O_STEP(step)
    );

    sound_frame_sequencer #(.CLKS_PER_STEP(5), .DIV_WIDTH(3)) u_dut5 (
        .I_CLK(clk), .I_RESET(rst2), .I_SOUND_ON(1'b1),
        .O_LENGTH_TICK(len2), .O_SWEEP_TICK(swp2), .O_ENVELOPE_TICK(env2),
        .O_FRAME_WRAP(wrap2), .O_STEP(step2)
    );

    typedef struct packed {
        logic       rst;
        logic       son;
        logic [7:0] cycles;
        logic       len;
        logic       swp;
        logic       env;
        logic       wrap;
        logic [2:0] step;
    } vec_t;

    vec_t tbl[14];

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_outs(input string name, input logic l, input logic s, input logic e,
                              input logic w, input logic [2:0] st);
        check({name, ".len"}, int'(len), int'(l));
        check({name, ".swp"}, int'(swp), int'(s));
        check({name, ".env"}, int'(env), int'(e));
        check({name, ".wrap"}, int'(wrap), int'(w));
        check({name, ".step"}, int'(step), int'(st));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        son = 1'b1;
        edges(1);
        rst = 1'b0;
    endtask

    int c_len, c_swp, c_env, c_wrap, bad_swp, bad_env, dbl;
    int first_env, last_env, period, c_len2;
    logic any_prev;

    initial begin
        rst  = 1'b1;
        son  = 1'b0;
        rst2 = 1'b1;

        // {rst, son, cycles, len, swp, env, wrap, step}, checked after the last cycle
        tbl[0]  = '{1'b1, 1'b1, 8'd1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd7};
        tbl[1]  = '{1'b0, 1'b1, 8'd3, 1'b0, 1'b0, 1'b0, 1'b0, 3'd7};
        tbl[2]  = '{1'b0, 1'b1, 8'd1, 1'b1, 1'b0, 1'b0, 1'b1, 3'd0};
        tbl[3]  = '{1'b0, 1'b1, 8'd1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0};
        tbl[4]  = '{1'b0, 1'b1, 8'd3, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1};
        tbl[5]  = '{1'b0, 1'b1, 8'd4, 1'b1, 1'b1, 1'b0, 1'b0, 3'd2};
        tbl[6]  = '{1'b0, 1'b1, 8'd1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2};
        tbl[7]  = '{1'b0, 1'b1, 8'd3, 1'b0, 1'b0, 1'b0, 1'b0, 3'd3};
        tbl[8]  = '{1'b0, 1'b1, 8'd4, 1'b1, 1'b0, 1'b0, 1'b0, 3'd4};
        tbl[9]  = '{1'b0, 1'b1, 8'd4, 1'b0, 1'b0, 1'b0, 1'b0, 3'd5};
        tbl[10] = '{1'b0, 1'b1, 8'd4, 1'b1, 1'b1, 1'b0, 1'b0, 3'd6};
        tbl[11] = '{1'b0, 1'b1, 8'd4, 1'b0, 1'b0, 1'b1, 1'b0, 3'd7};
        tbl[12] = '{1'b0, 1'b1, 8'd1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd7};
        tbl[13] = '{1'b0, 1'b1, 8'd3, 1'b1, 1'b0, 1'b0, 1'b1, 3'd0};

        #2;
        for (int i = 0; i < 14; i++) begin
            rst = tbl[i].rst;
            son = tbl[i].son;
            edges(int'(tbl[i].cycles));
            check_outs($sformatf("vec%0d", i), tbl[i].len, tbl[i].swp, tbl[i].env,
                       tbl[i].wrap, tbl[i].step);
        end

        // 64 cycles after reset: pulse counts and tick/step consistency
        do_reset();
        c_len = 0; c_swp = 0; c_env = 0; c_wrap = 0;
        bad_swp = 0; bad_env = 0; dbl = 0; any_prev = 1'b0;
        for (int i = 0; i < 64; i++) begin
            edges(1);
            c_len  += int'(len);
            c_swp  += int'(swp);
            c_env  += int'(env);
            c_wrap += int'(wrap);
            if (swp && step != 3'd2 && step != 3'd6) bad_swp++;
            if (env && step != 3'd7) bad_env++;
            if (any_prev && (len | swp | env | wrap)) dbl++;
            any_prev = len | swp | env | wrap;
        end
        check("cnt64.len", c_len, 8);
        check("cnt64.swp", c_swp, 4);
        check("cnt64.env", c_env, 2);
        check("cnt64.wrap", c_wrap, 2);
        check("cnt64.swp_step", bad_swp, 0);
        check("cnt64.env_step", bad_env, 0);
        check("cnt64.consecutive", dbl, 0);

        // Sound off mid-period at step 3, restored after 10 cycles
        do_reset();
        edges(17);
        check_outs("off.pre", 1'b0, 1'b0, 1'b0, 1'b0, 3'd3);
        son = 1'b0;
        c_len = 0;
        for (int i = 0; i < 10; i++) begin
            edges(1);
            c_len += int'(len | swp | env | wrap);
            if (step != 3'd7) c_len += 100;
        end
        check("off.quiet", c_len, 0);
        son = 1'b1;
        edges(3);
        check_outs("off.restore3", 1'b0, 1'b0, 1'b0, 1'b0, 3'd7);
        edges(1);
        check_outs("off.restore4", 1'b1, 1'b0, 1'b0, 1'b1, 3'd0);

        // Sound off exactly in the rollover cycle into step 6
        do_reset();
        edges(27);
        check_outs("coll.pre", 1'b0, 1'b0, 1'b0, 1'b0, 3'd5);
        son = 1'b0;
        edges(1);
        check_outs("coll.edge", 1'b0, 1'b0, 1'b0, 1'b0, 3'd7);
        edges(1);
        check_outs("coll.after", 1'b0, 1'b0, 1'b0, 1'b0, 3'd7);

        // Reset at step 5 while running
        do_reset();
        edges(26);
        check_outs("rst.pre", 1'b0, 1'b0, 1'b0, 1'b0, 3'd5);
        rst = 1'b1;
        edges(1);
        check_outs("rst.edge", 1'b0, 1'b0, 1'b0, 1'b0, 3'd7);
        rst = 1'b0;
        edges(3);
        check_outs("rst.wait", 1'b0, 1'b0, 1'b0, 1'b0, 3'd7);
        edges(1);
        check_outs("rst.restart", 1'b1, 1'b0, 1'b0, 1'b1, 3'd0);

        // Odd divider (5): envelope spacing and per-period length count
        rst2 = 1'b1;
        edges(1);
        rst2 = 1'b0;
        first_env = -1; last_env = -1; period = -1; c_len2 = 0; c_env = 0;
        for (int i = 1; i <= 80; i++) begin
            edges(1);
            if (i <= 40) c_len2 += int'(len2);
            if (env2) begin
                c_env++;
                if (first_env < 0) first_env = i;
                else if (period < 0) period = i - first_env;
                last_env = i;
            end
        end
        check("div5.first_env", first_env, 40);
        check("div5.env_period", period, 40);
        check("div5.env_count", c_env, 2);
        check("div5.len_per_period", c_len2, 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
